freq_gate_sched: RTL and testbench
==================================

# freq_gate_sched

Measurement sequencer for the frequency-meter path: generates the counting gate for the external edge counter, clears/latches it, hands the latched count to the binary-to-BCD converter with a start/done handshake, and publishes the result with a decimal-point position. With auto-ranging it picks 1 s / 0.1 s / 0.01 s gates so the 7-digit display never overflows. Sits between the `cf` edge counter and the BCD/display stage.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; 1 s gate = CLK_HZ cycles
- `CNT_W`, 24, edge-counter width
- `SETTLE_CYC`, 4, cycles waited after gate close for counter synchronizer flush (≥1)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `run_en`  in  1  level: continuous back-to-back measurements
- `start`  in  1  one-cycle pulse: single measurement when `run_en`=0
- `manual_range`  in  2  gate select when auto-range off: 0=1 s, 1=0.1 s, 2=0.01 s, 3 treated as 2
- `cnt_val`  in  CNT_W  edge-counter value
- `cnt_ovf`  in  1  edge counter saturated
- `bcd_done`  in  1  converter finished (pulse or level)
- `gate`  out  1  counter enable
- `cnt_clr`  out  1  one-cycle counter clear
- `bcd_bin`  out  CNT_W  latched count to converter
- `bcd_start`  out  1  one-cycle convert request
- `range`  out  2  gate used for current `bcd_bin`
- `dp_pos`  out  2  decimal point: equals `range` (0 = none, 1 = one digit, 2 = two digits, Hz units)
- `data_valid`  out  1  one-cycle pulse: new result published
- `over`  out  1  latched result exceeded 9_999_999 or `cnt_ovf`
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE → CLEAR → GATE → SETTLE → LATCH → (RERANGE | CONVERT) → PUBLISH → IDLE or CLEAR.
- IDLE: leave on `run_en`=1, or `start`=1.
- CLEAR: `cnt_clr`=1 for exactly 1 cycle; load gate timer with G = CLK_HZ/10^range.
- GATE: `gate`=1 for exactly G cycles.
- SETTLE: `gate`=0 for SETTLE_CYC cycles.
- LATCH: `bcd_bin`<=`cnt_val`; `over` <= (`cnt_val`>9_999_999)|`cnt_ovf`.
- RERANGE (auto only): taken if `over` and range<2; range+1, back to CLEAR, no publish, no `bcd_start`.
- CONVERT: `bcd_start`=1 on entry cycle only; wait for `bcd_done`, sampled from the cycle after `bcd_start` (done coincident with start ignored).
- PUBLISH: `data_valid`=1 for 1 cycle; `range`/`dp_pos` reflect this measurement. Auto: if `bcd_bin`<900_000 and range>0, range−1 applied to the next measurement (hysteresis vs. 1_000_000). Next: CLEAR if `run_en`, else IDLE.
- `run_en` falling during CLEAR/GATE/SETTLE: abort to IDLE next cycle, `gate`=0, nothing published. During LATCH/CONVERT/PUBLISH: finish and publish, then IDLE.
- `start` while busy ignored. At range 2 with `over`: publish with `over`=1.
- Manual mode: range sampled in CLEAR only; mid-measurement changes apply next cycle of measurement.

## Timing
- Reset: state IDLE, range 0, all outputs 0 (`bcd_bin`=0).
- Registered outputs; `gate` rises the cycle after `cnt_clr`, high exactly G cycles.
- Measurement latency start→`bcd_start`: 1+G+SETTLE_CYC+1 cycles after leaving IDLE; `data_valid` 1 cycle after accepted `bcd_done`.
- Reset mid-operation: immediate return to reset values, `gate` drops asynchronously.

## Configuration
- `FREQ_AUTORANGE_EN` defined: RERANGE and step-down logic present, `manual_range` ignored.
- Undefined: range = `manual_range` sampled in CLEAR; RERANGE never taken; `over` still flagged and published.

## Structure
- Package `freq_pkg`: state enum, range encoding, constants `DISP_MAX`=9_999_999, `DN_TH`=900_000, function gate_len(CLK_HZ, range).
- Sub-module `gate_timer`: loadable down-counter, `load`/`len`/`expired`; width $clog2(CLK_HZ+1).

## Test plan
- CLK_HZ=1000, manual range 0, cf 7 edges/gate → `gate` high 1000 cycles, `bcd_bin`=7, `dp_pos`=0, one `data_valid`.
- Auto, range 0, `cnt_val`=12_000_000 at LATCH → no `bcd_start`, rerange to 1, gate 100 cycles; next `cnt_val`=1_200_000 → published, `range`=1.
- Auto, range 1, `cnt_val`=500_000 → published at range 1, next gate 1000 cycles (range 0).
- Range 2, `cnt_ovf`=1 → published, `over`=1, `range`=2.
- `run_en` dropped mid-GATE → `gate`=0 next cycle, IDLE, no `data_valid`.
- `bcd_done` held high during `bcd_start` cycle, released, re-pulsed 5 cycles later → `data_valid` only after the later pulse; `rst` asserted mid-CONVERT → all outputs 0 immediately.

Source files
------------

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared types, constants and gate-length helper for the frequency-meter sequencer
// Contents:
//   state_t      sequencer states
//   RNG_*        gate range encoding (0 = 1 s, 1 = 0.1 s, 2 = 0.01 s)
//   DISP_MAX     largest count the 7-digit display can show
//   DN_TH        step-down threshold, kept below 1_000_000 for hysteresis
//   clamp_range  folds the unused code 3 onto the 0.01 s gate
//   gate_len     gate length in clock cycles for a given range
package freq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_GATE,
      ST_SETTLE,
      ST_LATCH,
      ST_RERANGE,
      ST_CONVERT,
      ST_PUBLISH
   } state_t;

   localparam logic [1:0] RNG_1S    = 2'd0;
   localparam logic [1:0] RNG_100MS = 2'd1;
   localparam logic [1:0] RNG_10MS  = 2'd2;

   localparam int unsigned DISP_MAX = 9_999_999;
   localparam int unsigned DN_TH    = 900_000;

   function automatic logic [1:0] clamp_range(input logic [1:0] rng);
      return (rng == 2'd3) ? RNG_10MS : rng;
   endfunction

   function automatic int unsigned gate_len(input int unsigned clk_hz, input logic [1:0] rng);
      case (clamp_range(rng))
         RNG_1S:    return clk_hz;
         RNG_100MS: return clk_hz / 10;
         default:   return clk_hz / 100;
      endcase
   endfunction

endpackage

// File: rtl/freq_gate_sched_gate_timer.sv
// rtl/freq_gate_sched_gate_timer.sv - loadable down-counter timing the gate and settle windows
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      load len into the counter (has priority over en)
//   en        count down by one while non-zero
//   len       value to load, in cycles
//   expired   high during the last counted cycle (count <= 1)
module gate_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] len,
   output logic         expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= len;
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // A window loaded with N lasts exactly N enabled cycles: the Nth one sees count 1.
   assign expired = (r_cnt <= W'(1));

endmodule

// File: rtl/freq_gate_sched.sv
// rtl/freq_gate_sched.sv - frequency-meter measurement sequencer (gate, latch, convert, publish)
// Build option: define FREQ_AUTORANGE_EN for auto-ranging (RERANGE and step-down present,
// manual_range ignored); otherwise the range comes from manual_range, sampled in CLEAR.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run_en          continuous back-to-back measurements while high
//   start           single-measurement pulse, honoured only in IDLE
//   manual_range    gate select in manual mode (3 acts as 2)
//   cnt_val/cnt_ovf external edge counter value / saturation flag
//   bcd_done        converter finished
//   gate/cnt_clr    counter enable / one-cycle counter clear
//   bcd_bin         latched count, bcd_start one-cycle convert request
//   range/dp_pos    gate of the published result / decimal-point position
//   data_valid      one-cycle publish pulse, over = result exceeds display or counter saturated
//   busy            sequencer not idle
module freq_gate_sched
   import freq_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int CNT_W      = 24,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_en,
   input  logic             start,
   input  logic [1:0]       manual_range,
   input  logic [CNT_W-1:0] cnt_val,
   input  logic             cnt_ovf,
   input  logic             bcd_done,
   output logic             gate,
   output logic             cnt_clr,
   output logic [CNT_W-1:0] bcd_bin,
   output logic             bcd_start,
   output logic [1:0]       range,
   output logic [1:0]       dp_pos,
   output logic             data_valid,
   output logic             over,
   output logic             busy
);

   localparam int TW = $clog2(CLK_HZ + 1);
   localparam logic [CNT_W-1:0] L_DISP_MAX = CNT_W'(DISP_MAX);

   state_t           r_state, w_state_nx;
   logic             r_gate, r_cnt_clr, r_bcd_start, r_data_valid, r_over, r_busy;
   logic [CNT_W-1:0] r_bcd_bin;
   logic [1:0]       r_range, r_meas_rng, w_rng_sel;
   logic             r_cont;
   logic             w_tmr_load, w_tmr_en, w_tmr_exp;
   logic [TW-1:0]    w_tmr_len;
   logic             w_over_now, w_rerange, w_abort;

   assign w_over_now = (cnt_val > L_DISP_MAX) | cnt_ovf;
   // Only a measurement launched by run_en is cancelled when run_en drops.
   assign w_abort    = r_cont & ~run_en;

`ifdef FREQ_AUTORANGE_EN
   localparam logic [CNT_W-1:0] L_DN_TH = CNT_W'(DN_TH);
   logic [1:0] r_cur_rng;
   logic [1:0] w_unused_manual;

   assign w_unused_manual = manual_range;
   assign w_rng_sel       = r_cur_rng;
   assign w_rerange       = w_over_now & (r_meas_rng != RNG_10MS);

   // r_cur_rng is the range the next CLEAR will use.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur_rng <= RNG_1S;
      end else if (r_state == ST_RERANGE) begin
         r_cur_rng <= r_meas_rng + 2'd1;
      end else if ((r_state == ST_PUBLISH) && (r_bcd_bin < L_DN_TH) && (r_meas_rng != RNG_1S)) begin
         r_cur_rng <= r_meas_rng - 2'd1;
      end
   end
`else
   assign w_rng_sel = clamp_range(manual_range);
   assign w_rerange = 1'b0;
`endif

   gate_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (w_tmr_load),
      .en      (w_tmr_en),
      .len     (w_tmr_len),
      .expired (w_tmr_exp)
   );

   always_comb begin
      w_state_nx = r_state;
      w_tmr_load = 1'b0;
      w_tmr_en   = 1'b0;
      w_tmr_len  = TW'(gate_len(CLK_HZ, w_rng_sel));
      case (r_state)
         ST_IDLE:    if (run_en || start) w_state_nx = ST_CLEAR;
         ST_CLEAR: begin
            if (w_abort) begin
               w_state_nx = ST_IDLE;
            end else begin
               w_state_nx = ST_GATE;
               w_tmr_load = 1'b1;
            end
         end
         ST_GATE: begin
            w_tmr_en = 1'b1;
            if (w_abort) begin
               w_state_nx = ST_IDLE;
            end else if (w_tmr_exp) begin
               // Reuse the timer for the settle window.
               w_state_nx = ST_SETTLE;
               w_tmr_load = 1'b1;
               w_tmr_len  = TW'(SETTLE_CYC);
            end
         end
         ST_SETTLE: begin
            w_tmr_en = 1'b1;
            if (w_abort)        w_state_nx = ST_IDLE;
            else if (w_tmr_exp) w_state_nx = ST_LATCH;
         end
         ST_LATCH:   w_state_nx = w_rerange ? ST_RERANGE : ST_CONVERT;
         ST_RERANGE: w_state_nx = ST_CLEAR;
         // A done level still high from the start cycle must not count.
         ST_CONVERT: if (bcd_done && !r_bcd_start) w_state_nx = ST_PUBLISH;
         ST_PUBLISH: w_state_nx = run_en ? ST_CLEAR : ST_IDLE;
         default:    w_state_nx = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_gate       <= 1'b0;
         r_cnt_clr    <= 1'b0;
         r_bcd_start  <= 1'b0;
         r_data_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_over       <= 1'b0;
         r_bcd_bin    <= '0;
         r_range      <= RNG_1S;
         r_meas_rng   <= RNG_1S;
         r_cont       <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_gate       <= (w_state_nx == ST_GATE);
         r_cnt_clr    <= (w_state_nx == ST_CLEAR);
         r_bcd_start  <= (w_state_nx == ST_CONVERT) && (r_state != ST_CONVERT);
         r_data_valid <= (w_state_nx == ST_PUBLISH);
         r_busy       <= (w_state_nx != ST_IDLE);
         if ((r_state == ST_IDLE) || (r_state == ST_PUBLISH)) begin
            r_cont <= run_en;
         end
         if (r_state == ST_CLEAR) begin
            r_meas_rng <= w_rng_sel;
         end
         if (r_state == ST_LATCH) begin
            r_bcd_bin <= cnt_val;
            r_over    <= w_over_now;
         end
         if ((w_state_nx == ST_PUBLISH) && (r_state != ST_PUBLISH)) begin
            r_range <= r_meas_rng;
         end
      end
   end

   assign gate       = r_gate;
   assign cnt_clr    = r_cnt_clr;
   assign bcd_bin    = r_bcd_bin;
   assign bcd_start  = r_bcd_start;
   assign range      = r_range;
   assign dp_pos     = r_range;
   assign data_valid = r_data_valid;
   assign over       = r_over;
   assign busy       = r_busy;

endmodule

// File: tb/tb_freq_gate_sched.sv
// tb/tb_freq_gate_sched.sv - self-checking bench for freq_gate_sched
module tb_freq_gate_sched;

   localparam int CLK_HZ = 1000;
   localparam int CNT_W  = 24;
   localparam int SETTLE = 4;
   localparam int unsigned MAXD = 9_999_999;
   localparam int unsigned TH   = 900_000;

   logic             clk = 1'b0, rst = 1'b1, run_en = 1'b0, start = 1'b0;
   logic             cnt_ovf = 1'b0, bcd_done = 1'b0, use_cf = 1'b0, edge_in = 1'b0;
   logic [1:0]       manual_range = 2'd0;
   logic [CNT_W-1:0] cnt_val, direct_val = '0, cf_cnt = '0;
   logic             gate, cnt_clr, bcd_start, data_valid, over, busy;
   logic [CNT_W-1:0] bcd_bin;
   logic [1:0]       range, dp_pos;

   freq_gate_sched #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE)) dut (
      .clk(clk), .rst(rst), .run_en(run_en), .start(start), .manual_range(manual_range),
      .cnt_val(cnt_val), .cnt_ovf(cnt_ovf), .bcd_done(bcd_done), .gate(gate), .cnt_clr(cnt_clr),
      .bcd_bin(bcd_bin), .bcd_start(bcd_start), .range(range), .dp_pos(dp_pos),
      .data_valid(data_valid), .over(over), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External edge counter stand-in.
   assign cnt_val = use_cf ? cf_cnt : direct_val;
   always @(posedge clk) begin
      if (cnt_clr)              cf_cnt <= '0;
      else if (gate && edge_in) cf_cnt <= cf_cnt + 1'b1;
   end

   // Monitor, edge generator and converter responder.
   int g_run = 0, n_start = 0, n_dv = 0, clr_cyc = 0, rise_cyc = 0, start_cyc = 0;
   int dv_cyc = 0, done_cyc = 0, pend = 0, resp_mode = 0, resp_d = 1, edges_left = 0;
   int gate_lens[$];
   logic [CNT_W-1:0] p_bin;
   logic [1:0]       p_rng, p_dp;
   logic             p_over;
   int m_rng = 0;

   always @(negedge clk) begin
      if (rst) begin
         g_run = 0; pend = 0; bcd_done = 1'b0; edge_in = 1'b0;
      end else begin
         if (cnt_clr) clr_cyc = cyc;
         if (gate) begin
            if (g_run == 0) rise_cyc = cyc;
            g_run++;
         end else if (g_run > 0) begin
            gate_lens.push_back(g_run);
            g_run = 0;
         end
         if (data_valid) begin
            n_dv++; dv_cyc = cyc;
            p_bin = bcd_bin; p_rng = range; p_dp = dp_pos; p_over = over;
         end
         edge_in = (edges_left > 0) && gate && (g_run % 100 == 3);
         if (edge_in) edges_left--;
         if (bcd_start) begin
            n_start++; start_cyc = cyc;
            bcd_done = (resp_mode == 1);
            if (resp_mode != 2) pend = cyc + ((resp_mode == 1) ? 6 : resp_d);
         end else if (pend > 0 && cyc == pend) begin
            bcd_done = 1'b1; done_cyc = cyc; pend = 0;
         end else begin
            bcd_done = 1'b0;
         end
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int g_of(input int r);
      return (r >= 2) ? CLK_HZ / 100 : (r == 1) ? CLK_HZ / 10 : CLK_HZ;
   endfunction

   // One single-shot measurement, checked against the range/publish rules.
   task automatic meas(input logic [1:0] rng, input int unsigned val, input bit ovf,
                       input int mode, input int d, input bit cf);
      int  exp_g[$];
      int  pr, budget, dv0, st0, ng;
      bit  ov;
      ov = (val > MAXD) || ovf;
`ifdef FREQ_AUTORANGE_EN
      pr = m_rng;
      exp_g.push_back(g_of(pr));
      while (ov && pr < 2) begin
         pr++;
         exp_g.push_back(g_of(pr));
      end
      m_rng = (val < TH && pr > 0) ? pr - 1 : pr;
`else
      pr = (rng > 2'd2) ? 2 : int'(rng);
      exp_g.push_back(g_of(pr));
`endif
      budget = 300;
      foreach (exp_g[i]) budget += exp_g[i];
      @(negedge clk);
      manual_range = rng; direct_val = val[CNT_W-1:0]; cnt_ovf = ovf;
      resp_mode = mode; resp_d = d; use_cf = cf; edges_left = cf ? 7 : 0;
      gate_lens.delete(); dv0 = n_dv; st0 = n_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (n_dv == dv0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      repeat (3) @(posedge clk);
      #2;
      check("dv_count", n_dv - dv0, 1);
      check("bcd_start_count", n_start - st0, 1);
      check("gate_count", gate_lens.size(), exp_g.size());
      ng = (gate_lens.size() < exp_g.size()) ? gate_lens.size() : exp_g.size();
      for (int i = 0; i < ng; i++) check("gate_len", gate_lens[i], exp_g[i]);
      check("gate_rise", rise_cyc - clr_cyc, 1);
      check("latency", start_cyc - clr_cyc, exp_g[exp_g.size()-1] + SETTLE + 2);
      check("dv_after_done", dv_cyc - done_cyc, 1);
      if (mode == 1) check("done_at_start_ignored", dv_cyc - start_cyc, 7);
      check("bin", p_bin, val);
      check("range", p_rng, pr);
      check("dp_pos", p_dp, pr);
      check("over", p_over, ov);
      check("busy_after", busy, 0);
   endtask

   task automatic cont_test();
      int dv0, st0, b, er;
`ifdef FREQ_AUTORANGE_EN
      er = m_rng;
`else
      er = 1;
`endif
      @(negedge clk);
      manual_range = 2'd1; direct_val = 950_000; cnt_ovf = 1'b0; use_cf = 1'b0;
      resp_mode = 0; resp_d = 2; dv0 = n_dv; run_en = 1'b1;
      b = 3000;
      while (n_dv == dv0 && b > 0) begin @(posedge clk); b--; end
      @(negedge clk);
      check("cont_clr_after_dv", cnt_clr, 1);
      check("cont_range", p_rng, er);
      st0 = n_start;
      b = 3000;
      while (n_start == st0 && b > 0) begin @(posedge clk); b--; end
      @(negedge clk);
      run_en = 1'b0;
      b = 100;
      while (n_dv < dv0 + 2 && b > 0) begin @(posedge clk); b--; end
      repeat (3) @(posedge clk);
      #2;
      check("cont_dv_count", n_dv - dv0, 2);
      check("cont_bin", p_bin, 950_000);
      check("cont_stop_busy", busy, 0);
   endtask

   task automatic abort_test();
      int dv0, b;
      @(negedge clk);
      direct_val = 100; manual_range = 2'd0; dv0 = n_dv; run_en = 1'b1;
      b = 2000;
      while (g_run < 20 && b > 0) begin @(posedge clk); b--; end
      @(negedge clk);
      check("abort_gate_was_high", gate, 1);
      run_en = 1'b0;
      @(negedge clk);
      check("abort_gate", gate, 0);
      check("abort_busy", busy, 0);
      repeat (30) @(posedge clk);
      check("abort_no_dv", n_dv - dv0, 0);
   endtask

   task automatic reset_tests();
      int st0, b;
      @(negedge clk);
      direct_val = 4321; cnt_ovf = 1'b0; manual_range = 2'd2; resp_mode = 2; st0 = n_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      b = 3000;
      while (n_start == st0 && b > 0) begin @(posedge clk); b--; end
      repeat (2) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_bin", bcd_bin, 4321);
      #2 rst = 1'b1;
      #1;
      check("rst_conv_outs", {gate, cnt_clr, bcd_bin, bcd_start, range, dp_pos, data_valid, over, busy}, 0);
      @(negedge clk);
      rst = 1'b0; m_rng = 0; resp_mode = 0;
      @(negedge clk);
      manual_range = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      b = 300;
      while (g_run < 5 && b > 0) begin @(posedge clk); b--; end
      @(negedge clk);
      check("pre_rst_gate", gate, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_gate_async", gate, 0);
      check("rst_gate_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0; m_rng = 0;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned v;
      int          k;
      repeat (3) @(negedge clk);
      check("rst_outs", {gate, cnt_clr, bcd_bin, bcd_start, range, dp_pos, data_valid, over}, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      meas(2'd0, 7, 1'b0, 0, 3, 1'b1);
      meas(2'd3, 5, 1'b1, 0, 2, 1'b0);
      meas(2'd1, 500_000, 1'b0, 1, 0, 1'b0);
      meas(2'd0, 10_000_000, 1'b0, 0, 1, 1'b0);
      meas(2'd2, 9_999_999, 1'b0, 0, 4, 1'b0);
      for (int i = 0; i < 10; i++) begin
         k = $urandom_range(0, 3);
         case (k)
            0:       v = $urandom_range(0, 899_999);
            1:       v = $urandom_range(900_000, 9_999_999);
            2:       v = $urandom_range(10_000_000, 16_777_215);
            default: begin
               k = $urandom_range(0, 3);
               v = (k == 0) ? 899_999 : (k == 1) ? 900_000 : (k == 2) ? 9_999_999 : 10_000_000;
            end
         endcase
         meas(2'($urandom_range(0, 3)), v, ($urandom_range(0, 7) == 0), 0, $urandom_range(1, 6), 1'b0);
      end
      cont_test();
      abort_test();
      reset_tests();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
